// File: rtl/video_raster_gen.sv
// Character-based video raster generator: pixel divider, char/x/y/frame counters,
// registered sync/blank/active/interrupt decodes and one-clock strobes.
module video_raster_gen #(
  parameter int PIX_DIV      = 6,
  parameter int CHAR_PIX     = 8,
  parameter int H_TOTAL      = 56,
  parameter int H_ACTIVE     = 32,
  parameter int H_SYNC_START = 40,
  parameter int H_SYNC_LEN   = 4,
  parameter int V_TOTAL      = 320,
  parameter int V_ACTIVE     = 192,
  parameter int V_SYNC_START = 248,
  parameter int V_SYNC_LEN   = 4,
  parameter int INT_LINE     = 248,
  parameter int INT_LEN      = 64,
  parameter int FRAME_W      = 7
) (
  input  logic                        clk42_i,
  input  logic                        res_i,
  input  logic                        en_i,
  input  logic                        dscan_i,
  output logic                        pix_stb_o,
  output logic [$clog2(CHAR_PIX)-1:0] char_cnt_o,
  output logic [5:0]                  ray_cntx_o,
  output logic [8:0]                  ray_cnty_o,
  output logic [FRAME_W-1:0]          cnt_frame_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        hblank_o,
  output logic                        vblank_o,
  output logic                        active_o,
  output logic                        int_o,
  output logic                        line_stb_o,
  output logic                        frame_stb_o
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam int CW    = $clog2(CHAR_PIX);
  localparam int IW    = $clog2(INT_LEN + 1);

  localparam logic [DIV_W-1:0] DIV_LAST_N = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_D = DIV_W'(PIX_DIV / 2 - 1);
  localparam logic [CW-1:0]    CHAR_LAST  = CW'(CHAR_PIX - 1);
  localparam logic [5:0]       H_LAST     = 6'(H_TOTAL - 1);
  localparam logic [8:0]       V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [6:0]       H_ACT      = 7'(H_ACTIVE);
  localparam logic [6:0]       HS_BEG     = 7'(H_SYNC_START);
  localparam logic [6:0]       HS_END     = 7'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [9:0]       V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]       VS_BEG     = 10'(V_SYNC_START);
  localparam logic [9:0]       VS_END     = 10'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [8:0]       INT_Y      = 9'(INT_LINE);
  localparam logic [IW-1:0]    INT_LAST   = IW'(INT_LEN - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CW-1:0]      char_q, char_d;
  logic [5:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IW-1:0]      int_cnt_q, int_cnt_d;
  logic               dscan_q, dscan_d;
  logic               pix_stb_q, pix_stb_d, line_stb_q, line_stb_d, frame_stb_q, frame_stb_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, hblank_q, hblank_d;
  logic               vblank_q, vblank_d, active_q, active_d, int_q, int_d;

  logic [DIV_W-1:0] div_last;
  logic             tick, char_wrap, x_wrap, y_wrap;

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
  always_comb begin
    div_last    = dscan_q ? DIV_LAST_D : DIV_LAST_N;
    tick        = en_i && (div_q == div_last);
    div_d       = div_q;
    char_d      = char_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_d     = frame_q;
    dscan_d     = dscan_q;
    int_cnt_d   = int_cnt_q;
    int_d       = int_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    hblank_d    = hblank_q;
    vblank_d    = vblank_q;
    active_d    = active_q;
    pix_stb_d   = 1'b0;
    line_stb_d  = 1'b0;
    frame_stb_d = 1'b0;
    char_wrap   = 1'b0;
    x_wrap      = 1'b0;
    y_wrap      = 1'b0;

    if (en_i) div_d = tick ? '0 : div_q + 1'b1;

    if (tick) begin
      pix_stb_d = 1'b1;
      char_wrap = (char_q == CHAR_LAST);
      x_wrap    = char_wrap && (x_q == H_LAST);
      y_wrap    = x_wrap && (y_q == V_LAST);
      char_d    = char_wrap ? '0 : char_q + 1'b1;
      if (char_wrap) x_d = x_wrap ? '0 : x_q + 1'b1;
      if (x_wrap)    y_d = y_wrap ? '0 : y_q + 1'b1;
      if (y_wrap) begin
        frame_d = frame_q + 1'b1;
        // Scan rate may only change on a frame boundary so a frame never mixes periods.
        dscan_d = dscan_i;
      end
      line_stb_d  = x_wrap;
      frame_stb_d = y_wrap;

      hblank_d = ({1'b0, x_d} >= H_ACT);
      vblank_d = ({1'b0, y_d} >= V_ACT);
      active_d = !hblank_d && !vblank_d;
      hsync_d  = ({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END);
      vsync_d  = ({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END);

      // Interrupt window counts pixels, so it may run across a line wrap.
      if ((y_d == INT_Y) && (x_d == '0) && (char_d == '0)) begin
        int_d     = 1'b1;
        int_cnt_d = '0;
      end else if (int_q) begin
        if (int_cnt_q == INT_LAST) int_d = 1'b0;
        else int_cnt_d = int_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk42_i or posedge res_i) begin
    if (res_i) begin
      div_q       <= '0;
      char_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_q     <= '0;
      int_cnt_q   <= '0;
      dscan_q     <= 1'b0;
      pix_stb_q   <= 1'b0;
      line_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      active_q    <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      char_q      <= char_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_q     <= frame_d;
      int_cnt_q   <= int_cnt_d;
      dscan_q     <= dscan_d;
      pix_stb_q   <= pix_stb_d;
      line_stb_q  <= line_stb_d;
      frame_stb_q <= frame_stb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      active_q    <= active_d;
      int_q       <= int_d;
    end
  end

  assign pix_stb_o   = pix_stb_q;
  assign char_cnt_o  = char_q;
  assign ray_cntx_o  = x_q;
  assign ray_cnty_o  = y_q;
  assign cnt_frame_o = frame_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign hblank_o    = hblank_q;
  assign vblank_o    = vblank_q;
  assign active_o    = active_q;
  assign int_o       = int_q;
  assign line_stb_o  = line_stb_q;
  assign frame_stb_o = frame_stb_q;

endmodule

// File: tb/tb_video_raster_gen.sv
// Self-checking bench for video_raster_gen on a shrunken raster: a linear-pixel
// reference model feeds a scoreboard queue that is checked every clock.
module tb_video_raster_gen;

  localparam int PIX_DIV      = 4;
  localparam int CHAR_PIX     = 2;
  localparam int H_TOTAL      = 8;
  localparam int H_ACTIVE     = 5;
  localparam int H_SYNC_START = 6;
  localparam int H_SYNC_LEN   = 1;
  localparam int V_TOTAL      = 6;
  localparam int V_ACTIVE     = 4;
  localparam int V_SYNC_START = 4;
  localparam int V_SYNC_LEN   = 1;
  localparam int INT_LINE     = 4;
  localparam int INT_LEN      = 20;
  localparam int FRAME_W      = 2;
  localparam int LINE_PIX     = CHAR_PIX * H_TOTAL;
  localparam int FRAME_PIX    = LINE_PIX * V_TOTAL;
  localparam int INT_P0       = INT_LINE * LINE_PIX;
  localparam int FRAME_CLK    = FRAME_PIX * PIX_DIV;

  typedef struct packed {
    logic [0:0]         ch;
    logic [5:0]         x;
    logic [8:0]         y;
    logic [FRAME_W-1:0] fr;
    logic pix, line, frm, hs, vs, hb, vb, act, intr;
  } exp_t;

  logic clk42_i = 1'b0;
  logic res_i   = 1'b1;
  logic en_i    = 1'b0;
  logic dscan_i = 1'b0;
  logic               pix_stb_o, hsync_o, vsync_o, hblank_o, vblank_o, active_o, int_o;
  logic               line_stb_o, frame_stb_o;
  logic [0:0]         char_cnt_o;
  logic [5:0]         ray_cntx_o;
  logic [8:0]         ray_cnty_o;
  logic [FRAME_W-1:0] cnt_frame_o;

  always #5 clk42_i = ~clk42_i;

  video_raster_gen #(
    .PIX_DIV(PIX_DIV), .CHAR_PIX(CHAR_PIX), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_LEN(H_SYNC_LEN), .V_TOTAL(V_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC_START(V_SYNC_START), .V_SYNC_LEN(V_SYNC_LEN),
    .INT_LINE(INT_LINE), .INT_LEN(INT_LEN), .FRAME_W(FRAME_W)
  ) dut (
    .clk42_i(clk42_i), .res_i(res_i), .en_i(en_i), .dscan_i(dscan_i),
    .pix_stb_o(pix_stb_o), .char_cnt_o(char_cnt_o), .ray_cntx_o(ray_cntx_o),
    .ray_cnty_o(ray_cnty_o), .cnt_frame_o(cnt_frame_o), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .hblank_o(hblank_o), .vblank_o(vblank_o), .active_o(active_o),
    .int_o(int_o), .line_stb_o(line_stb_o), .frame_stb_o(frame_stb_o)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // Reference model: divider plus a linear pixel index within the frame.
  int   m_div, m_p, m_frame;
  logic m_dl, m_pix, m_line, m_frm, m_started;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("%s differs: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_p = 0; m_frame = 0;
    m_dl = 1'b0; m_pix = 1'b0; m_line = 1'b0; m_frm = 1'b0; m_started = 1'b0;
  endtask

  task automatic model_step();
    int dmax;
    if (res_i) begin
      model_reset();
    end else begin
      m_pix = 1'b0; m_line = 1'b0; m_frm = 1'b0;
      if (en_i) begin
        dmax = m_dl ? PIX_DIV / 2 - 1 : PIX_DIV - 1;
        if (m_div == dmax) begin
          m_div     = 0;
          m_p       = (m_p + 1) % FRAME_PIX;
          m_pix     = 1'b1;
          m_started = 1'b1;
          m_line    = (m_p % LINE_PIX) == 0;
          m_frm     = (m_p == 0);
          if (m_frm) begin
            m_frame = (m_frame + 1) % (1 << FRAME_W);
            m_dl    = dscan_i;
          end
        end else begin
          m_div++;
        end
      end
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    int x, y;
    x = (m_p / CHAR_PIX) % H_TOTAL;
    y = m_p / LINE_PIX;
    e      = '0;
    e.ch   = 1'(m_p % CHAR_PIX);
    e.x    = 6'(x);
    e.y    = 9'(y);
    e.fr   = FRAME_W'(m_frame);
    e.pix  = m_pix;
    e.line = m_line;
    e.frm  = m_frm;
    if (m_started) begin
      e.hb   = (x >= H_ACTIVE);
      e.vb   = (y >= V_ACTIVE);
      e.act  = !e.hb && !e.vb;
      e.hs   = (x >= H_SYNC_START) && (x < H_SYNC_START + H_SYNC_LEN);
      e.vs   = (y >= V_SYNC_START) && (y < V_SYNC_START + V_SYNC_LEN);
      e.intr = (m_p >= INT_P0) && (m_p < INT_P0 + INT_LEN);
    end
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    e = sb_q.pop_front();
    check("char_cnt", 16'(char_cnt_o), 16'(e.ch));
    check("ray_cntx", 16'(ray_cntx_o), 16'(e.x));
    check("ray_cnty", 16'(ray_cnty_o), 16'(e.y));
    check("cnt_frame", 16'(cnt_frame_o), 16'(e.fr));
    check("strobes", {13'b0, pix_stb_o, line_stb_o, frame_stb_o}, {13'b0, e.pix, e.line, e.frm});
    check("flags", {10'b0, hsync_o, vsync_o, hblank_o, vblank_o, active_o, int_o},
          {10'b0, e.hs, e.vs, e.hb, e.vb, e.act, e.intr});
  endtask

  task automatic cycle();
    @(posedge clk42_i);
    model_step();
    sb_q.push_back(model_exp());
    #1;
    compare_out();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Runs until the pixel strobe that lands on linear position target, within budget.
  task automatic run_until(input string tag, input int target, input int budget);
    int   k;
    logic hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < budget) begin
      cycle();
      k++;
      hit = m_pix && (m_p == target);
    end
    check(tag, {15'b0, hit}, 16'd1);
  endtask

  initial begin
    model_reset();
    run(3);

    res_i = 1'b0;
    en_i  = 1'b1;
    run(2 * FRAME_CLK + 10);

    run_until("reach_line2", 2 * LINE_PIX, FRAME_CLK + 10);
    dscan_i = 1'b1;
    run(40);
    run_until("reach_wrap_dscan_on", 0, FRAME_CLK + 10);
    run(FRAME_CLK / 2 - 20);
    dscan_i = 1'b0;
    run_until("reach_wrap_dscan_off", 0, FRAME_CLK + 10);
    run(100);

    run_until("reach_midline", 2 * LINE_PIX + 5, FRAME_CLK + 10);
    run(1);
    en_i = 1'b0;
    run(50);
    en_i = 1'b1;
    run(100);

    run_until("reach_int10", INT_P0 + 9, FRAME_CLK + 10);
    run(1);
    #2;
    res_i = 1'b1;
    #1;
    model_reset();
    sb_q.push_back(model_exp());
    compare_out();
    run(2);
    res_i = 1'b0;
    run(4 * FRAME_CLK + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
